// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: encodings shared by the multicycle RISC-V control path
// (main FSM, ALU decoder, datapath). Holds the 4-bit state enum, the
// supported opcode constants, the mux-select / ALUOp encodings and the
// packed control word produced by the state decoder.
// Optional feature macro: MAIN_FSM_JALR_EN (jalr support in main_fsm).
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH        = 4'd0,
      S_DECODE       = 4'd1,
      S_MEM_ADR      = 4'd2,
      S_MEM_READ     = 4'd3,
      S_MEM_WB       = 4'd4,
      S_MEM_WRITE    = 4'd5,
      S_EXECUTE_R    = 4'd6,
      S_ALU_WB       = 4'd7,
      S_EXECUTE_I    = 4'd8,
      S_JAL          = 4'd9,
      S_BEQ          = 4'd10,
      S_EXECUTE_JALR = 4'd11
   } state_e;

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_R_TYPE = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_BEQ    = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_e;

   typedef enum logic [1:0] {
      SRCA_PC     = 2'b00,
      SRCA_OLD_PC = 2'b01,
      SRCA_RS1    = 2'b10
   } src_a_e;

   typedef enum logic [1:0] {
      SRCB_RS2  = 2'b00,
      SRCB_IMM  = 2'b01,
      SRCB_FOUR = 2'b10
   } src_b_e;

   typedef enum logic [1:0] {
      RES_ALU_OUT    = 2'b00,
      RES_DATA       = 2'b01,
      RES_ALU_RESULT = 2'b10
   } result_src_e;

   typedef struct packed {
      alu_op_e     alu_op;
      src_a_e      alu_src_a;
      src_b_e      alu_src_b;
      result_src_e result_src;
      logic        adr_src;
      logic        ir_write;
      logic        pc_update;
      logic        branch;
      logic        reg_write;
      logic        mem_write;
   } ctrl_t;

   // All-zero control word: every select at encoding 00, no writes.
   localparam ctrl_t CTRL_IDLE = '{
      alu_op:     ALUOP_ADD,
      alu_src_a:  SRCA_PC,
      alu_src_b:  SRCB_RS2,
      result_src: RES_ALU_OUT,
      adr_src:    1'b0,
      ir_write:   1'b0,
      pc_update:  1'b0,
      branch:     1'b0,
      reg_write:  1'b0,
      mem_write:  1'b0
   };

endpackage

// File: rtl/main_fsm_if.sv
// main_fsm_if: bundle between the main control FSM and the datapath.
//   op          datapath -> FSM  opcode field of the instruction register
//   ALUOp       FSM -> ALU decoder
//   ALUSrcA/B, ResultSrc, AdrSrc        FSM -> datapath mux selects
//   IRWrite, PCUpdate, Branch, RegWrite, MemWrite  FSM -> write enables
//   illegal_op  FSM -> flag for an unsupported opcode seen in Decode
//   state       FSM -> current state encoding (debug)
// The master modport is the FSM side, the slave modport the datapath side.
interface main_fsm_if;

   logic [6:0] op;
   logic [1:0] ALUOp;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic       AdrSrc;
   logic       IRWrite;
   logic       PCUpdate;
   logic       Branch;
   logic       RegWrite;
   logic       MemWrite;
   logic       illegal_op;
   logic [3:0] state;

   modport master (
      input  op,
      output ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
      output IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
      output illegal_op, state
   );

   modport slave (
      output op,
      input  ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
      input  IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
      input  illegal_op, state
   );

endinterface

// File: rtl/main_fsm_out_dec.sv
// main_fsm_out_dec: purely combinational state -> control-word decode for
// the multicycle main FSM (Moore outputs).
//   state  in   current (or reset-substituted) state
//   ctrl   out  packed mux selects, ALUOp and write enables
// Encodings with no defined behaviour decode to the all-zero word.
// Optional feature macro: MAIN_FSM_JALR_EN (adds ExecuteJALR decode).
module main_fsm_out_dec
   import riscv_ctrl_pkg::*;
(
   input  state_e state,
   output ctrl_t  ctrl
);

   always_comb begin
      // NOTE: default the whole word first so every path assigns every bit
      // and no latch is inferred.
      ctrl = CTRL_IDLE;
      case (state)
         S_FETCH: begin
            ctrl.alu_src_b  = SRCB_FOUR;
            ctrl.result_src = RES_ALU_RESULT;
            ctrl.ir_write   = 1'b1;
            ctrl.pc_update  = 1'b1;
         end
         S_DECODE: begin
            ctrl.alu_src_a = SRCA_OLD_PC;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEM_ADR: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEM_READ: ctrl.adr_src = 1'b1;
         S_MEM_WB: begin
            ctrl.result_src = RES_DATA;
            ctrl.reg_write  = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl.adr_src   = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         S_EXECUTE_R: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_ALU_WB: ctrl.reg_write = 1'b1;
         S_EXECUTE_I: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         // JAL: ALUOut (rs1+imm for jalr, OldPC+imm for jal) goes to PC,
         // while the ALU forms OldPC+4 for the ALUWB write of rd.
         S_JAL: begin
            ctrl.alu_src_a = SRCA_OLD_PC;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.pc_update = 1'b1;
         end
         S_BEQ: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_op    = ALUOP_SUB;
            ctrl.branch    = 1'b1;
         end
`ifdef MAIN_FSM_JALR_EN
         S_EXECUTE_JALR: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_IMM;
         end
`endif
         default: ctrl = CTRL_IDLE;
      endcase
   end

endmodule

// File: rtl/main_fsm.sv
// main_fsm: multicycle RISC-V main control FSM. Sequences each instruction
// through Fetch, Decode and its execute/writeback states, driving ALUOp,
// every datapath mux select and every write enable.
//   clk    in  system clock, rising edge
//   reset  in  synchronous active-high reset, forces Fetch
//   bus    master side of main_fsm_if (op in; controls, illegal_op, state out)
// Optional feature macro: MAIN_FSM_JALR_EN adds jalr (ExecuteJALR -> JAL ->
// ALUWB); without it opcode 1100111 is treated as unsupported.
module main_fsm
   import riscv_ctrl_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   main_fsm_if.master    bus
);

   state_e state_q, state_d;
   state_e dec_state;
   ctrl_t  ctrl;
   logic   illegal_raw;

   // NOTE: reset is synchronous, so it lives inside the clocked block and
   // the state register updates with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Next state. op is only looked at in Decode and MemAdr.
   always_comb begin
      state_d     = S_FETCH;
      illegal_raw = 1'b0;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: state_d = S_MEM_ADR;
               OP_R_TYPE:    state_d = S_EXECUTE_R;
               OP_I_ALU:     state_d = S_EXECUTE_I;
               OP_JAL:       state_d = S_JAL;
               OP_BEQ:       state_d = S_BEQ;
`ifdef MAIN_FSM_JALR_EN
               OP_JALR:      state_d = S_EXECUTE_JALR;
`endif
               default:      illegal_raw = 1'b1;
            endcase
         end
         S_MEM_ADR:   state_d = (bus.op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  state_d = S_MEM_WB;
         S_EXECUTE_R: state_d = S_ALU_WB;
         S_EXECUTE_I: state_d = S_ALU_WB;
         S_JAL:       state_d = S_ALU_WB;
`ifdef MAIN_FSM_JALR_EN
         S_EXECUTE_JALR: state_d = S_JAL;
`endif
         // MemWB, MemWrite, ALUWB, BEQ and unreachable codes return to Fetch.
         default:     state_d = S_FETCH;
      endcase
   end

   // During reset the selects show Fetch values even if the register still
   // holds a mid-instruction state; write enables are then gated off below.
   assign dec_state = reset ? S_FETCH : state_q;

   main_fsm_out_dec u_out_dec (
      .state (dec_state),
      .ctrl  (ctrl)
   );

   always_comb begin
      bus.ALUOp      = ctrl.alu_op;
      bus.ALUSrcA    = ctrl.alu_src_a;
      bus.ALUSrcB    = ctrl.alu_src_b;
      bus.ResultSrc  = ctrl.result_src;
      bus.AdrSrc     = ctrl.adr_src;
      bus.IRWrite    = ctrl.ir_write  & ~reset;
      bus.PCUpdate   = ctrl.pc_update & ~reset;
      bus.Branch     = ctrl.branch    & ~reset;
      bus.RegWrite   = ctrl.reg_write & ~reset;
      bus.MemWrite   = ctrl.mem_write & ~reset;
      bus.illegal_op = illegal_raw    & ~reset;
      bus.state      = state_q;
   end

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: self-checking bench for main_fsm. A behavioural model
// derives, per instruction, the list of states that follow Decode and the
// control values of each state; a compare process checks the DUT against
// it on every falling edge. Directed sequences with literal expectations
// pin the model, then randomized opcodes, op glitches and resets follow.
// Optional feature macro: MAIN_FSM_JALR_EN (jalr expectations).
module tb_main_fsm;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   main_fsm_if bus ();

   main_fsm dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCUpdate,
   //  Branch, RegWrite, MemWrite}
   logic [13:0] dut_word;
   assign dut_word = {bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                      bus.AdrSrc, bus.IRWrite, bus.PCUpdate, bus.Branch,
                      bus.RegWrite, bus.MemWrite};

   // ---------------- behavioural model ----------------
   typedef int iq_t[$];

   // States an instruction walks through after Decode; empty = unsupported.
   function automatic iq_t seq_for(input logic [6:0] o);
      iq_t s;
      case (o)
         7'b0000011: s = '{2, 3, 4};
         7'b0100011: s = '{2, 5};
         7'b0110011: s = '{6, 7};
         7'b0010011: s = '{8, 7};
         7'b1101111: s = '{9, 7};
         7'b1100011: s = '{10};
`ifdef MAIN_FSM_JALR_EN
         7'b1100111: s = '{11, 9, 7};
`endif
         default: ;
      endcase
      return s;
   endfunction

   function automatic logic [13:0] exp_word(input int st, input logic rst);
      logic [13:0] w;
      case (rst ? 0 : st)
         0:  w = {2'b00, 2'b00, 2'b10, 2'b10, 6'b011000};
         1:  w = {2'b00, 2'b01, 2'b01, 2'b00, 6'b000000};
         2:  w = {2'b00, 2'b10, 2'b01, 2'b00, 6'b000000};
         3:  w = {2'b00, 2'b00, 2'b00, 2'b00, 6'b100000};
         4:  w = {2'b00, 2'b00, 2'b00, 2'b01, 6'b000010};
         5:  w = {2'b00, 2'b00, 2'b00, 2'b00, 6'b100001};
         6:  w = {2'b10, 2'b10, 2'b00, 2'b00, 6'b000000};
         7:  w = {2'b00, 2'b00, 2'b00, 2'b00, 6'b000010};
         8:  w = {2'b10, 2'b10, 2'b01, 2'b00, 6'b000000};
         9:  w = {2'b00, 2'b01, 2'b10, 2'b00, 6'b001000};
         10: w = {2'b01, 2'b10, 2'b00, 2'b00, 6'b000100};
`ifdef MAIN_FSM_JALR_EN
         11: w = {2'b00, 2'b10, 2'b01, 2'b00, 6'b000000};
`endif
         default: w = '0;
      endcase
      if (rst) w[4:0] = '0;
      return w;
   endfunction

   int  mdl_state = 0;
   iq_t mdl_q;
   bit  mdl_valid = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         mdl_state = 0;
         mdl_q.delete();
      end else if (mdl_state == 1) begin
         mdl_q = seq_for(bus.op);
         mdl_state = (mdl_q.size() == 0) ? 0 : mdl_q.pop_front();
      end else if (mdl_q.size() != 0) begin
         mdl_state = mdl_q.pop_front();
      end else begin
         mdl_state = (mdl_state == 0) ? 1 : 0;
      end
      mdl_valid = 1'b1;
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (mdl_valid) begin
         check("state", {28'd0, bus.state}, mdl_state);
         check("ctrl", {18'd0, dut_word}, {18'd0, exp_word(mdl_state, reset)});
         check("illegal_op", {31'd0, bus.illegal_op},
               {31'd0, (mdl_state == 1) && !reset && (seq_for(bus.op).size() == 0)});
      end
   end

   // ---------------- directed + random stimulus ----------------
   logic [3:0]  cap_st [16];
   logic [13:0] cap_w  [16];
   logic        cap_ill[16];

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Sample n consecutive cycles starting with the current one.
   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         cap_st[i]  = bus.state;
         cap_w[i]   = dut_word;
         cap_ill[i] = bus.illegal_op;
         if (i < n - 1) cycle();
      end
   endtask

   function automatic logic [31:0] packed_states(input int n);
      logic [31:0] p = '0;
      for (int i = 0; i < n; i++) p = {p[27:0], cap_st[i]};
      return p;
   endfunction

   // Bit i = selected control bit of captured cycle i.
   function automatic logic [15:0] bit_vec(input int n, input int b);
      logic [15:0] v = '0;
      for (int i = 0; i < n; i++) v[i] = cap_w[i][b];
      return v;
   endfunction

   function automatic logic [6:0] pick_op();
      logic [6:0] o;
      case ($urandom_range(0, 8))
         0: o = 7'b0000011;
         1: o = 7'b0100011;
         2: o = 7'b0110011;
         3: o = 7'b0010011;
         4: o = 7'b1100011;
         5: o = 7'b1101111;
         6: o = 7'b1100111;
         7: o = 7'b1110011;
         default: o = 7'($urandom);
      endcase
      return o;
   endfunction

   initial begin
      logic [15:0] ill_vec;
      reset  = 1'b1;
      bus.op = 7'b0110011;
      repeat (2) cycle();
      reset = 1'b0;
      #1;
      check("first fetch IRWrite", {31'd0, bus.IRWrite}, 32'd1);
      check("model lw length", seq_for(7'b0000011).size(), 32'd3);

      // R-type
      capture(5);
      check("R seq", packed_states(5), 32'h01670);
      check("R ALUOp in 6", {30'd0, cap_w[2][13:12]}, 32'd2);
      check("R RegWrite", {16'd0, bit_vec(5, 1)}, 32'h08);

      // lw
      bus.op = 7'b0000011;
      capture(6);
      check("lw seq", packed_states(6), 32'h012340);
      check("lw AdrSrc in 3", {31'd0, cap_w[3][5]}, 32'd1);
      check("lw ResultSrc in 4", {30'd0, cap_w[4][7:6]}, 32'd1);
      check("lw RegWrite", {16'd0, bit_vec(6, 1)}, 32'h10);

      // sw
      bus.op = 7'b0100011;
      capture(5);
      check("sw seq", packed_states(5), 32'h01250);
      check("sw MemWrite", {16'd0, bit_vec(5, 0)}, 32'h08);
      check("sw RegWrite", {16'd0, bit_vec(5, 1)}, 32'h00);

      // beq
      bus.op = 7'b1100011;
      capture(4);
      check("beq seq", packed_states(4), 32'h01A0);
      check("beq ALUOp in 10", {30'd0, cap_w[2][13:12]}, 32'd1);
      check("beq Branch", {16'd0, bit_vec(4, 2)}, 32'h04);

      // jal
      bus.op = 7'b1101111;
      capture(5);
      check("jal seq", packed_states(5), 32'h01970);
      check("jal PCUpdate in 9", {31'd0, cap_w[2][3]}, 32'd1);

      // unsupported opcode
      bus.op = 7'b1110011;
      capture(3);
      ill_vec = '0;
      for (int i = 0; i < 3; i++) ill_vec[i] = cap_ill[i];
      check("illegal seq", packed_states(3), 32'h010);
      check("illegal flag", {16'd0, ill_vec}, 32'h2);

      // jalr
      bus.op = 7'b1100111;
`ifdef MAIN_FSM_JALR_EN
      capture(6);
      check("jalr seq", packed_states(6), 32'h01B970);
`else
      capture(3);
      ill_vec = '0;
      for (int i = 0; i < 3; i++) ill_vec[i] = cap_ill[i];
      check("jalr seq", packed_states(3), 32'h010);
      check("jalr illegal", {16'd0, ill_vec}, 32'h2);
`endif

      // reset during MemWB aborts the writeback
      bus.op = 7'b0000011;
      repeat (4) cycle();
      check("pre-reset state", {28'd0, bus.state}, 32'd4);
      reset = 1'b1;
      #1;
      check("RegWrite under reset", {31'd0, bus.RegWrite}, 32'd0);
      check("ResultSrc under reset", {30'd0, bus.ResultSrc}, 32'd2);
      cycle();
      check("state after reset", {28'd0, bus.state}, 32'd0);
      reset = 1'b0;
      #1;
      check("IRWrite after reset", {31'd0, bus.IRWrite}, 32'd1);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (reset) begin
            if ($urandom_range(0, 1) == 0) reset = 1'b0;
         end else if ($urandom_range(0, 99) < 2) begin
            reset = 1'b1;
         end else if (mdl_state == 0) begin
            bus.op = pick_op();
         end else if (mdl_state >= 3 && $urandom_range(0, 3) == 0) begin
            bus.op = 7'($urandom);
         end
         cycle();
      end

      cycle();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
